// File: rtl/vram_fill_seq.sv
// VRAM fill sequencer: writes a programmable region of VRAM with one of four data patterns.
// Latency: first write 1 cycle after the start edge; done pulses 1 cycle after the last write or abort.
// Backpressure: i_hold stalls the write stream with no loss; i_abort ends the fill early.
module vram_fill_seq #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int FILL_ON_RESET = 1,
  parameter int DEF_BASE      = 0,
  parameter int DEF_LENGTH    = 4096,
  parameter int DEF_MODE      = 0,
  parameter int DEF_PATTERN   = 8'h0F
) (
  input  logic                  i_clk_12_5875,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base,
  input  logic [ADDR_WIDTH:0]   i_cfg_length,
  input  logic [ADDR_WIDTH-1:0] i_cfg_stride,
  input  logic [1:0]            i_cfg_mode,
  input  logic [DATA_WIDTH-1:0] i_cfg_pattern,
  input  logic                  i_hold,
  input  logic                  i_abort,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_write_enable,
  output logic                  o_in_progress,
  output logic                  o_done
);

  localparam logic [1:0] C_CONST   = 2'd0;
  localparam logic [1:0] C_INC     = 2'd1;
  localparam logic [1:0] C_ADDR_LO = 2'd2;
  localparam logic [1:0] C_CHECKER = 2'd3;

  // Auto fill after reset uses a unit stride so the default region is contiguous.
  localparam logic [ADDR_WIDTH-1:0] C_DEF_BASE   = ADDR_WIDTH'(DEF_BASE);
  localparam logic [ADDR_WIDTH:0]   C_DEF_LEN    = (ADDR_WIDTH+1)'(DEF_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] C_DEF_STRIDE = ADDR_WIDTH'(1);
  localparam logic [1:0]            C_DEF_MODE   = 2'(DEF_MODE);
  localparam logic [DATA_WIDTH-1:0] C_DEF_PAT    = DATA_WIDTH'(DEF_PATTERN);
  localparam logic                  C_AUTO       = (FILL_ON_RESET != 0);
  localparam logic [ADDR_WIDTH:0]   C_ONE        = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_auto;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_pat;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic                  r_inprog;
  logic                  r_done;

  logic                  w_latch;
  logic                  w_issue;
  logic                  w_we_nxt;
  logic                  w_inprog_nxt;
  logic                  w_done_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [ADDR_WIDTH:0]   w_idx_inc;
  logic [DATA_WIDTH-1:0] w_idx_lo;
  logic [DATA_WIDTH-1:0] w_addr_lo;
  logic [ADDR_WIDTH-1:0] w_sel_base;
  logic [ADDR_WIDTH:0]   w_sel_len;
  logic [ADDR_WIDTH-1:0] w_sel_stride;
  logic [1:0]            w_sel_mode;
  logic [DATA_WIDTH-1:0] w_sel_pat;

  // The pending auto fill takes the defaults; otherwise the host config is used.
  assign w_sel_base   = r_auto ? C_DEF_BASE   : i_cfg_base;
  assign w_sel_len    = r_auto ? C_DEF_LEN    : i_cfg_length;
  assign w_sel_stride = r_auto ? C_DEF_STRIDE : i_cfg_stride;
  assign w_sel_mode   = r_auto ? C_DEF_MODE   : i_cfg_mode;
  assign w_sel_pat    = r_auto ? C_DEF_PAT    : i_cfg_pattern;

  assign w_idx_inc = r_idx + C_ONE;
  assign w_idx_lo  = DATA_WIDTH'(r_idx);
  assign w_addr_lo = DATA_WIDTH'(r_cur);

  assign o_data         = r_data;
  assign o_address      = r_addr;
  assign o_write_enable = r_we;
  assign o_in_progress  = r_inprog;
  assign o_done         = r_done;

  // State register.
  always_ff @(posedge i_clk_12_5875 or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and next output strobes; abort outranks hold, start outranks abort in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_issue      = 1'b0;
    w_we_nxt     = 1'b0;
    w_inprog_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_auto || i_start) begin
          w_latch     = 1'b1;
          w_state_nxt = (w_sel_len == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        w_inprog_nxt = 1'b1;
        if (i_abort) begin
          w_state_nxt = S_FINISH;
        end else if (!i_hold) begin
          w_issue  = 1'b1;
          w_we_nxt = 1'b1;
          if (w_idx_inc == r_len) w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pattern generator for the write currently being issued.
  always_comb begin
    w_data_nxt = r_pat;
    case (r_mode)
      C_CONST:   w_data_nxt = r_pat;
      C_INC:     w_data_nxt = r_pat + w_idx_lo;
      C_ADDR_LO: w_data_nxt = w_addr_lo;
      C_CHECKER: w_data_nxt = r_idx[0] ? ~r_pat : r_pat;
    endcase
  end

  // Config latch, write counter/address accumulator and registered outputs.
  always_ff @(posedge i_clk_12_5875 or posedge i_rst) begin
    if (i_rst) begin
      r_auto   <= C_AUTO;
      r_len    <= '0;
      r_idx    <= '0;
      r_cur    <= '0;
      r_stride <= '0;
      r_mode   <= '0;
      r_pat    <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_inprog <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_we     <= w_we_nxt;
      r_inprog <= w_inprog_nxt;
      r_done   <= w_done_nxt;
      if (w_latch) begin
        r_auto   <= 1'b0;
        r_len    <= w_sel_len;
        r_idx    <= '0;
        r_cur    <= w_sel_base;
        r_stride <= w_sel_stride;
        r_mode   <= w_sel_mode;
        r_pat    <= w_sel_pat;
      end
      if (w_issue) begin
        r_addr <= r_cur;
        r_data <= w_data_nxt;
        r_idx  <= w_idx_inc;
        r_cur  <= r_cur + r_stride;
      end
    end
  end

endmodule
